// File: rtl/corner_seq_pkg.sv
// Shared state encoding and derived-size helpers for the corner window sequencer.
package corner_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Each centred window delays its centre by half a window in both directions.
    function automatic int unsigned calc_lat(input int unsigned frame_w,
                                             input int unsigned win,
                                             input int unsigned stages);
        return stages * ((win / 2) * frame_w + win / 2);
    endfunction

    function automatic int unsigned calc_npix(input int unsigned frame_w,
                                              input int unsigned frame_h);
        return frame_w * frame_h;
    endfunction

    function automatic int unsigned calc_r(input int unsigned win,
                                           input int unsigned stages);
        return stages * (win / 2);
    endfunction

endpackage

// File: rtl/raster_xy_counter.sv
// Raster position counter: x wraps at X_SIZE-1 and carries into y, y wraps at Y_SIZE-1.
// x/y show the position for the current cycle; clr restarts at the origin in the same cycle.
module raster_xy_counter #(
    parameter int unsigned X_SIZE = 200,
    parameter int unsigned Y_SIZE = 200,
    parameter int unsigned CW     = 16
) (
    input  logic          pixClk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam logic [CW-1:0] X_LAST = CW'(X_SIZE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(Y_SIZE - 1);

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] x_base, y_base;

    always_comb begin
        x_base = clr ? '0 : x_q;
        y_base = clr ? '0 : y_q;
        x_d    = x_base;
        y_d    = y_base;
        if (en) begin
            if (x_base == X_LAST) begin
                x_d = '0;
                y_d = (y_base == Y_LAST) ? '0 : y_base + 1'b1;
            end else begin
                x_d = x_base + 1'b1;
            end
        end
        x = x_base;
        y = y_base;
    end

    always_ff @(posedge pixClk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/corner_window_sequencer.sv
// Raster-scan control, latency compensation and response tagging for the cascaded
// Sobel / structure-tensor windows. out_border is generated only with CORNER_SEQ_BORDER_EN.
module corner_window_sequencer
    import corner_seq_pkg::*;
#(
    parameter int unsigned FRAME_W = 200,
    parameter int unsigned FRAME_H = 200,
    parameter int unsigned WIN     = 3,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned CW      = 16
) (
    input  logic          pixClk,
    input  logic          rst,
    input  logic          sof,
    input  logic          pix_valid,
    output logic          shift_en,
    output logic          pad_sel,
    output logic [CW-1:0] in_x,
    output logic [CW-1:0] in_y,
    output logic          out_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_border,
    output logic          frame_done,
    output logic          frame_abort,
    output logic          busy
);

    // state | meaning
    // IDLE  | waiting for sof together with a valid pixel
    // RUN   | shifting real pixels, stalls follow pix_valid
    // FLUSH | shifting zero padding until the last response reaches the centre
    // DONE  | frame_done pulse; a sof here starts the next frame without a gap

    localparam int unsigned     LAT        = calc_lat(FRAME_W, WIN, STAGES);
    localparam int unsigned     NPIX       = calc_npix(FRAME_W, FRAME_H);
    localparam int unsigned     KW         = $clog2(NPIX + LAT + 1);
    localparam logic [KW-1:0]   K_LAT      = KW'(LAT);
    localparam logic [KW-1:0]   K_LAST_PIX = KW'(NPIX - 1);
    localparam logic [KW-1:0]   K_LAST     = KW'(NPIX + LAT - 1);

    seq_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d, k_cur;
    logic          start, restart, clr, in_step;

    always_comb begin
        start       = sof & pix_valid;
        state_d     = state_q;
        shift_en    = 1'b0;
        pad_sel     = 1'b0;
        restart     = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    restart  = 1'b1;
                    shift_en = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    restart     = 1'b1;
                    frame_abort = 1'b1;
                    shift_en    = 1'b1;
                    state_d     = ST_RUN;
                end else if (pix_valid) begin
                    shift_en = 1'b1;
                    if (k_q == K_LAST_PIX) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (start) begin
                    restart     = 1'b1;
                    frame_abort = 1'b1;
                    shift_en    = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    shift_en = 1'b1;
                    pad_sel  = 1'b1;
                    if (k_q == K_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
                if (start) begin
                    restart  = 1'b1;
                    shift_en = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // DONE also clears the counters so IDLE always presents the origin.
        clr       = restart | (state_q == ST_DONE);
        k_cur     = clr ? '0 : k_q;
        k_d       = shift_en ? k_cur + 1'b1 : k_cur;
        out_valid = shift_en & (k_cur >= K_LAT);
        in_step   = shift_en & ~pad_sel & (k_cur != K_LAST_PIX);
    end

    always_ff @(posedge pixClk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    raster_xy_counter #(
        .X_SIZE(FRAME_W),
        .Y_SIZE(FRAME_H),
        .CW    (CW)
    ) u_in_xy (
        .pixClk(pixClk),
        .rst   (rst),
        .clr   (clr),
        .en    (in_step),
        .x     (in_x),
        .y     (in_y)
    );

    raster_xy_counter #(
        .X_SIZE(FRAME_W),
        .Y_SIZE(FRAME_H),
        .CW    (CW)
    ) u_out_xy (
        .pixClk(pixClk),
        .rst   (rst),
        .clr   (clr),
        .en    (out_valid),
        .x     (out_x),
        .y     (out_y)
    );

`ifdef CORNER_SEQ_BORDER_EN
    localparam int unsigned   R    = calc_r(WIN, STAGES);
    localparam logic [CW-1:0] R_C  = CW'(R);
    localparam logic [CW-1:0] X_HI = CW'(FRAME_W - R);
    localparam logic [CW-1:0] Y_HI = CW'(FRAME_H - R);

    assign out_border = out_valid & ((out_x < R_C) | (out_x >= X_HI) |
                                     (out_y < R_C) | (out_y >= Y_HI));
`else
    assign out_border = 1'b0;
`endif

endmodule

// File: doc/corner_window_sequencer.md
Name: corner_window_sequencer

Overview:
- Raster-scan controller for the two-stage corner pipeline: a 3x3 Sobel window feeding a 3x3 structure-tensor window, both shift-register windows sized to the frame width.
- Tracks input pixel position and generates the common shift enable for both windows.
- Compensates the cumulative window latency, flushes the pipeline with zero padding at end of frame, and tags each corner-response pixel with its true (x,y), a valid strobe and a border flag.
- Sits between the BMP stream reader and the BMP stream writers.

Parameters:
- FRAME_W, 200, frame width in pixels (must match the window frame_width).
- FRAME_H, 200, frame height in lines.
- WIN, 3, window edge length, odd.
- STAGES, 2, number of cascaded centred windows.
- CW, 16, coordinate counter width.

Ports:
- pixClk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- sof  in  1  start-of-frame pulse; coincides with pixel 0 when pix_valid=1.
- pix_valid  in  1  input pixel present this cycle.
- shift_en  out  1  shift enable to every window stage.
- pad_sel  out  1  1 = feed 0 into the first window instead of pixel data (flush).
- in_x, in_y  out  CW each  position of the pixel being shifted in.
- out_valid  out  1  response at window centre corresponds to a real pixel.
- out_x, out_y  out  CW each  coordinates of that response pixel.
- out_border  out  1  response depends on out-of-frame samples.
- frame_done  out  1  one-cycle pulse after the last response.
- frame_abort  out  1  one-cycle pulse when sof restarts a frame in progress.
- busy  out  1  state is not IDLE.

Behaviour:
- Constant LAT = STAGES*((WIN/2)*FRAME_W + WIN/2). Default LAT = 402.
- Constant NPIX = FRAME_W*FRAME_H.
- States: IDLE, RUN, FLUSH, DONE.
- Reset: state IDLE. All outputs 0. All counters 0.
- IDLE:
  - shift_en=0.
  - sof & pix_valid -> RUN. Pixel 0 is shifted that cycle: shift_en=1, in_x=0, in_y=0.
- RUN:
  - shift_en = pix_valid, pad_sel=0.
  - Input counter k increments on each shift; in_x wraps at FRAME_W-1 and increments in_y.
  - The shift of pixel k=NPIX-1 moves to FLUSH.
- FLUSH:
  - shift_en=1 and pad_sel=1 every cycle (no stall).
  - k keeps incrementing; in_x and in_y hold their last values.
  - After LAT flush shifts -> DONE.
- DONE:
  - frame_done=1 for exactly one cycle, then IDLE.
- Output tagging:
  - On a shift with k >= LAT: out_valid=1 and output index j = k-LAT; out_x = j mod FRAME_W, out_y = j div FRAME_W, kept as running counters (no divider).
  - out_valid=0 on non-shift cycles; out_x/out_y hold.
  - All output signals are combinational from current state and counters, aligned with the shift edge (zero added latency).
- out_border, with the macro defined: 1 when out_x < R, out_x >= FRAME_W-R, out_y < R, or out_y >= FRAME_H-R, where R = STAGES*(WIN/2) (default 2).
- Stalls:
  - pix_valid=0 in RUN: shift_en=0, all counters hold, out_valid=0.
  - Pipeline position is preserved across any stall length.
- sof & pix_valid while in RUN or FLUSH:
  - frame_abort=1 that cycle.
  - Counters restart with that pixel as k=0; state RUN.
  - No frame_done for the aborted frame.
- sof without pix_valid is ignored.
- sof during DONE: frame_done still pulses; the new frame starts and the state goes to RUN.
- rst mid-frame: immediate return to IDLE with all outputs 0 on the next edge.
- Every valid frame produces exactly NPIX out_valid pulses, in raster order.

Optional Feature:
- Macro CORNER_SEQ_BORDER_EN.
- Defined: out_border computed as above.
- Undefined: out_border tied to 0 and the comparators are removed; downstream treats every pixel as interior.

Decomposition:
- Package corner_seq_pkg holds:
  - the state encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3);
  - localparam functions for LAT, NPIX and R.
- One natural sub-module, raster_xy_counter (enable, clear, x/y with wrap). It is instantiated twice: once for input position, once for output position.

Test Plan:
- FRAME_W=8, FRAME_H=6 (LAT=18), continuous pix_valid from sof:
  - first out_valid on the 19th shift with out=(0,0);
  - last out_valid=(7,5) on the 18th flush cycle;
  - frame_done on the next cycle;
  - exactly 48 out_valid pulses.
- Same frame with CORNER_SEQ_BORDER_EN defined: exactly 8 non-border responses, covering x=2..5 and y=2..3. Macro undefined: out_border never 1.
- Random pix_valid gaps (about 30% idle): shift_en mirrors pix_valid in RUN; out sequence identical to the continuous case; pad_sel=1 only during the 18 flush cycles.
- sof & pix_valid reasserted at k=20:
  - frame_abort pulse that cycle; in_x=0, in_y=0;
  - next out_valid after 18 further shifts;
  - no frame_done from the first frame.
- rst asserted at k=30: next cycle busy=0, shift_en=0, out_valid=0, all coordinates 0; a following sof starts cleanly at (0,0).
- Back-to-back frames, sof in the DONE cycle: frame_done pulses once; the second frame produces 48 responses with no extra gap.
